// File: rtl/ext_arbiter.sv
// ext_arbiter: two-requester round-robin arbiter that extends the granted
// immediate from IN_W to OUT_W bits into a single-entry output register.
//
// Configuration macro: EXT_ARBITER_SIGN_EXT_EN
//   defined   -> reqN_sext selects sign (1) or zero (0) extension
//   undefined -> reqN_sext is ignored, every result is zero-extended
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req0_/req1_valid, _data, _sext requester offers (immediate, extension mode)
//   req0_/req1_ready               combinational accept for the granted requester
//   out_valid, out_data, out_id    registered result and its source requester
//   out_ready                      consumer takes the result this cycle
//   done_count                     wrapping count of completed output transfers
module ext_arbiter #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [IN_W-1:0]  req0_data,
  input  logic [IN_W-1:0]  req1_data,
  input  logic             req0_sext,
  input  logic             req1_sext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_id,
  output logic [7:0]       done_count
);

  localparam int unsigned EXT_W = OUT_W - IN_W;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_id_q, out_id_d;
  logic [CNT_W-1:0]   done_count_q, done_count_d;
  logic               last_q, last_d;

  logic               grant_c;
  logic               can_accept_c;
  logic               accept_c;
  logic               out_xfer_c;
  logic [IN_W-1:0]    sel_data_c;
  logic [OUT_W-1:0]   ext_c;

  // Round-robin: on contention the requester not last granted wins.
  assign grant_c      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  // Register can take a new value when empty or when it drains this cycle.
  assign can_accept_c = !rst && ((state_q == EMPTY) || out_ready);
  assign accept_c     = can_accept_c && (req0_valid || req1_valid);
  assign out_xfer_c   = (state_q == FULL) && out_ready;

  assign req0_ready   = can_accept_c && req0_valid && !grant_c;
  assign req1_ready   = can_accept_c && req1_valid &&  grant_c;

  assign sel_data_c   = grant_c ? req1_data : req0_data;

`ifdef EXT_ARBITER_SIGN_EXT_EN
  logic sel_sext_c;
  assign sel_sext_c = grant_c ? req1_sext : req0_sext;
  assign ext_c = sel_sext_c ? {{EXT_W{sel_data_c[IN_W-1]}}, sel_data_c}
                            : {{EXT_W{1'b0}}, sel_data_c};
`else
  // Extension mode inputs are present but have no effect in this build.
  logic unused_sext;
  assign unused_sext = req0_sext ^ req1_sext;
  assign ext_c = {{EXT_W{1'b0}}, sel_data_c};
`endif

  // Next-state and register-load logic.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    done_count_d = done_count_q;
    last_d       = last_q;

    case (state_q)
      EMPTY: begin
        if (accept_c) state_d = FULL;
      end
      FULL: begin
        if (out_xfer_c && !accept_c) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (accept_c) begin
      out_data_d = ext_c;
      out_id_d   = grant_c;
      last_d     = grant_c;
    end

    if (out_xfer_c) done_count_d = done_count_q + CNT_W'(1);
  end

  // State register; reset drops any held result without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_id_q     <= 1'b0;
      done_count_q <= '0;
      last_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      done_count_q <= done_count_d;
      last_q       <= last_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign done_count = done_count_q;

endmodule

// File: doc/ext_arbiter.md
EXT_ARBITER -- requirements
Module: ext_arbiter

Interface
REQ-001 Parameter IN_W, default 4, shall set the width of the requester immediate field.
REQ-002 Parameter OUT_W, default 8, shall set the width of the extended result; OUT_W > IN_W is required.
REQ-003 clk  input  1  shall be the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  shall be a synchronous, active-high reset.
REQ-005 req0_valid, req1_valid  input  1 each  shall indicate that a requester offers a value.
REQ-006 req0_ready, req1_ready  output  1 each  shall indicate acceptance this cycle.
REQ-007 req0_data, req1_data  input  IN_W each  shall carry the immediate to be extended.
REQ-008 req0_sext, req1_sext  input  1 each  shall request sign extension (1) or zero extension (0).
REQ-009 out_valid  output  1  shall indicate that the output register holds a result.
REQ-010 out_ready  input  1  shall indicate that the consumer takes the result this cycle.
REQ-011 out_data  output  OUT_W  shall carry the extended result.
REQ-012 out_id  output  1  shall identify the source requester (0 or 1) of out_data.
REQ-013 done_count  output  8  shall count completed output transfers.

Function
REQ-014 A transfer shall occur on req side when reqN_valid && reqN_ready, and on output side when out_valid && out_ready.
REQ-015 The FSM shall have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Each reqN_ready shall be combinational: asserted only for the granted requester, and only when the state is EMPTY, or FULL with out_ready=1 (pass-through).
REQ-017 Grant shall be round-robin: with both valid, the requester not indicated by the last-granted pointer wins; with one valid, that one wins; the pointer updates only on an accepted request.
REQ-018 Latency shall be 1 cycle: a request accepted in cycle t appears on out_data/out_id with out_valid=1 in cycle t+1.
REQ-019 Extension: zero-extend shall be {OUT_W-IN_W zeros, data}; sign-extend shall replicate data[IN_W-1] into the upper OUT_W-IN_W bits.
REQ-020 EMPTY -> FULL on request accept; FULL -> EMPTY on output transfer with no accept; FULL stays FULL (register reloaded) on a simultaneous output transfer and accept.
REQ-021 While FULL and out_ready=0, out_data, out_id and out_valid shall hold stable and both reqN_ready shall be 0.
REQ-022 done_count shall increment by 1 on each output transfer and wrap 255 -> 0.
REQ-023 A requester shall not be starved: with both continuously valid, grants shall alternate 0,1,0,1.

Reset
REQ-024 On rst=1 at a clock edge: state EMPTY, out_valid=0, out_data=0, out_id=0, done_count=0, last-granted pointer=1 (requester 0 wins first).
REQ-025 While rst=1, req0_ready and req1_ready shall be 0; a result held mid-operation shall be discarded and not counted.

Configuration
REQ-026 Macro EXT_ARBITER_SIGN_EXT_EN defined: reqN_sext selects sign or zero extension per REQ-019.
REQ-027 Macro EXT_ARBITER_SIGN_EXT_EN undefined: reqN_sext ports remain but are ignored; all results are zero-extended.

Verification
REQ-028 Reset, then req0_valid=1, data=4'b1010, sext=1, out_ready=1 -> next cycle out_valid=1, out_data=8'hFA (macro defined), 8'h0A (undefined), out_id=0.
REQ-029 Both valid continuously, out_ready=1 -> accepted sources 0,1,0,1 on consecutive cycles; done_count increments every cycle after the first.
REQ-030 FULL with out_ready=0 for 3 cycles -> out_data stable, req0_ready=req1_ready=0, done_count unchanged; out_ready=1 -> transfer plus same-cycle accept of the next request.
REQ-031 Only req1 valid, data=4'b0111, sext=1 -> out_data=8'h07, out_id=1; pointer then favours req0.
REQ-032 256 output transfers from reset -> done_count returns to 0.
REQ-033 rst asserted while FULL -> next cycle out_valid=0, done_count=0, out_data=0.
